one_hot_det: RTL and testbench
==============================

ONE_HOT_DET -- requirements
Module: one_hot_det

Interface
REQ-001 Parameter: width, default 16, number of input bits; legal range 1..64.
REQ-002 Derived localparam: cnt_width = clogb(width+1), bits needed to hold 0..width; 5 for width=16.
REQ-003 Port: clk  input  1  single clock; all registers rising-edge triggered.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: data  input  [0:width-1]  vector under test; index 0 is the MSB.
REQ-006 Port: en  input  1  capture enable for the registered outputs.
REQ-007 Port: one_hot  output  1  combinational; 1 when at most one bit of data is set.
REQ-008 Port: count  output  [0:cnt_width-1]  combinational population count of data; unsigned, MSB first.
REQ-009 Port: one_hot_q  output  1  registered copy of one_hot.
REQ-010 Port: count_q  output  [0:cnt_width-1]  registered copy of count.

Function
REQ-011 count SHALL equal the number of 1 bits in data, exactly, for every input value; no saturation or wrap, since cnt_width covers width.
REQ-012 one_hot SHALL be 1 iff count <= 1.
REQ-013 data all-zero SHALL give one_hot=1; exactly one set bit SHALL give one_hot=1; two or more set bits SHALL give one_hot=0.
REQ-014 one_hot and count SHALL depend only on the current data, with no dependence on clk, reset or en.
REQ-015 one_hot and count SHALL settle within the same cycle; zero-cycle latency.
REQ-016 one_hot and count SHALL be invariant to bit position, so any permutation of data gives the same outputs.
REQ-017 count SHALL be built as an adder tree of 1-bit inputs, with each level's sums widened by one bit, log2(width) levels deep.
REQ-018 one_hot SHALL be built as a log-depth tree of (any, multi) pairs:
- any = OR of the two children's any;
- multi = OR of both children's multi, plus the AND of both children's any.
- one_hot = NOT of the root's multi.
- one_hot SHALL NOT be derived by comparing count.
REQ-019 width=1 SHALL give one_hot=1 always and count=data[0].
REQ-020 Odd or non-power-of-two width SHALL be supported; unpaired tree nodes pass through unchanged.
REQ-021 On a rising clk edge with en=1 and reset=0:
- one_hot_q <= one_hot;
- count_q <= count.
REQ-022 With en=0, one_hot_q and count_q SHALL hold their values.
REQ-023 There SHALL be no latches and no combinational loops.

Reset
REQ-024 While reset=1, one_hot_q SHALL be 1 and count_q SHALL be 0, consistent with all-zero data; this SHALL take effect immediately, without waiting for a clock edge.
REQ-025 Reset SHALL NOT affect one_hot or count.
REQ-026 Reset asserted mid-operation SHALL override en; capture SHALL resume on the first rising edge after reset is deasserted.

Verification
REQ-027 width=16, exhaustive data 0x0000..0xFFFF, one value per cycle, checked at negedge:
- one_hot == (popcount <= 1);
- count == popcount;
- zero mismatches allowed.
REQ-028 Directed single values:
- data=0x0000 -> one_hot=1, count=0;
- data=0x8000 -> one_hot=1, count=1;
- data=0x0001 -> one_hot=1, count=1.
REQ-029 Directed multi-bit values:
- data=0x0003 -> one_hot=0, count=2;
- data=0x8001 -> one_hot=0, count=2;
- data=0xFFFF -> one_hot=0, count=16 (5'b10000).
REQ-030 Registered path:
- en=1 with data=0x0104 -> after the next posedge, one_hot_q=0 and count_q=2;
- then en=0 and data=0x0000 -> the registered outputs still hold 0 and 2 after two posedges.
REQ-031 Asynchronous reset:
- assert reset between edges with count_q=2 -> count_q=0 and one_hot_q=1 before the next posedge;
- deassert reset with en=1 and data=0x0010 -> after the next posedge, one_hot_q=1 and count_q=1.
REQ-032 Parameter sweep: width = 1, 3, 5, 8 exhaustive -> same checks as REQ-027.

Source files
------------

// File: rtl/one_hot_det.sv
// one_hot_det: population count and at-most-one-set-bit detection over data,
// with copies of both captured into registers when en is high.
module one_hot_det #(
    parameter  int width     = 16,
    localparam int cnt_width = $clog2(width + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [0:width-1]     data,
    input  logic                 en,
    output logic                 one_hot,
    output logic [0:cnt_width-1] count,
    output logic                 one_hot_q,
    output logic [0:cnt_width-1] count_q
);
    localparam int levels = width > 1 ? $clog2(width) : 0;

    function automatic int nodes(int lv);
        return (width + (1 << lv) - 1) >> lv;
    endfunction

    // Level l holds nodes(l) live entries; the rest are tied off.
    logic [cnt_width-1:0] s [0:levels][0:width-1];
    logic                 a [0:levels][0:width-1];
    logic                 m [0:levels][0:width-1];

    for (genvar i = 0; i < width; i++) begin : g_leaf
        assign s[0][i] = cnt_width'(data[i]);
        assign a[0][i] = data[i];
        assign m[0][i] = 1'b0;
    end

    for (genvar l = 0; l < levels; l++) begin : g_lvl
        for (genvar i = 0; i < width; i++) begin : g_node
            if (2 * i + 1 < nodes(l)) begin : g_pair
                // Level-l sums fit in l+1 bits; each add widens by one.
                assign s[l+1][i] = cnt_width'({1'b0, s[l][2*i][l:0]} + {1'b0, s[l][2*i+1][l:0]});
                assign a[l+1][i] = a[l][2*i] | a[l][2*i+1];
                assign m[l+1][i] = m[l][2*i] | m[l][2*i+1] | (a[l][2*i] & a[l][2*i+1]);
            end else if (2 * i < nodes(l)) begin : g_pass
                assign s[l+1][i] = s[l][2*i];
                assign a[l+1][i] = a[l][2*i];
                assign m[l+1][i] = m[l][2*i];
            end else begin : g_none
                assign s[l+1][i] = '0;
                assign a[l+1][i] = 1'b0;
                assign m[l+1][i] = 1'b0;
            end
        end
    end

    assign count   = s[levels][0];
    assign one_hot = ~m[levels][0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            one_hot_q <= 1'b1;
            count_q   <= '0;
        end else if (en) begin
            one_hot_q <= one_hot;
            count_q   <= count;
        end
    end
endmodule

// File: tb/tb_one_hot_det.sv
// tb_one_hot_det: directed table, exhaustive sweeps at widths 1/3/5/8/16,
// and hand-written register/reset sequences.
module tb_one_hot_det;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] data;
    logic [0:0]  d1;
    logic [2:0]  d3;
    logic [4:0]  d5;
    logic [7:0]  d8;

    logic       oh16, ohq16, oh1, ohq1, oh3, ohq3, oh5, ohq5, oh8, ohq8;
    logic [4:0] cnt16, cntq16;
    logic [0:0] cnt1, cntq1;
    logic [1:0] cnt3, cntq3;
    logic [2:0] cnt5, cntq5;
    logic [3:0] cnt8, cntq8;

    always #5 clk = ~clk;

    one_hot_det #(.width(16)) dut (.clk(clk), .reset(reset), .data(data), .en(en),
        .one_hot(oh16), .count(cnt16), .one_hot_q(ohq16), .count_q(cntq16));
    one_hot_det #(.width(1)) dut1 (.clk(clk), .reset(reset), .data(d1), .en(en),
        .one_hot(oh1), .count(cnt1), .one_hot_q(ohq1), .count_q(cntq1));
    one_hot_det #(.width(3)) dut3 (.clk(clk), .reset(reset), .data(d3), .en(en),
        .one_hot(oh3), .count(cnt3), .one_hot_q(ohq3), .count_q(cntq3));
    one_hot_det #(.width(5)) dut5 (.clk(clk), .reset(reset), .data(d5), .en(en),
        .one_hot(oh5), .count(cnt5), .one_hot_q(ohq5), .count_q(cntq5));
    one_hot_det #(.width(8)) dut8 (.clk(clk), .reset(reset), .data(d8), .en(en),
        .one_hot(oh8), .count(cnt8), .one_hot_q(ohq8), .count_q(cntq8));

    typedef struct {
        logic [15:0] d;
        logic        oh;
        logic [4:0]  cnt;
        logic        sweep;
    } vec_t;

    vec_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (data=%h)", name, act, exp, data);
        end
    endtask

    function automatic int pop(input logic [15:0] v);
        return $countones(v);
    endfunction

    // Scoreboard: each driven vector is checked on the following negedge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            vec_t e;
            e = q.pop_front();
            chk("oh16", 32'(oh16), 32'(e.oh));
            chk("cnt16", 32'(cnt16), 32'(e.cnt));
            if (e.sweep) begin
                chk("oh1", 32'(oh1), 32'(pop(16'(d1)) <= 1));
                chk("cnt1", 32'(cnt1), 32'(pop(16'(d1))));
                chk("oh3", 32'(oh3), 32'(pop(16'(d3)) <= 1));
                chk("cnt3", 32'(cnt3), 32'(pop(16'(d3))));
                chk("oh5", 32'(oh5), 32'(pop(16'(d5)) <= 1));
                chk("cnt5", 32'(cnt5), 32'(pop(16'(d5))));
                chk("oh8", 32'(oh8), 32'(pop(16'(d8)) <= 1));
                chk("cnt8", 32'(cnt8), 32'(pop(16'(d8))));
            end
        end
    end

    vec_t tbl[8];

    initial begin
        tbl[0] = '{16'h0000, 1'b1, 5'd0,  1'b0};
        tbl[1] = '{16'h8000, 1'b1, 5'd1,  1'b0};
        tbl[2] = '{16'h0001, 1'b1, 5'd1,  1'b0};
        tbl[3] = '{16'h0003, 1'b0, 5'd2,  1'b0};
        tbl[4] = '{16'h8001, 1'b0, 5'd2,  1'b0};
        tbl[5] = '{16'hFFFF, 1'b0, 5'd16, 1'b0};
        tbl[6] = '{16'h0400, 1'b1, 5'd1,  1'b0};
        tbl[7] = '{16'h7FFF, 1'b0, 5'd15, 1'b0};

        reset = 1'b1;
        en    = 1'b0;
        data  = 16'h0000;
        d1 = '0; d3 = '0; d5 = '0; d8 = '0;
        #3;
        chk("rst_ohq", 32'(ohq16), 32'd1);
        chk("rst_cntq", 32'(cntq16), 32'd0);
        chk("rst_ohq8", 32'(ohq8), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[k]) begin
            @(posedge clk);
            #1;
            data = tbl[k].d;
            q.push_back(tbl[k]);
        end

        for (int v = 0; v < 65536; v++) begin
            vec_t e;
            @(posedge clk);
            #1;
            data = v[15:0];
            d1 = v[0:0];
            d3 = v[2:0];
            d5 = v[4:0];
            d8 = v[7:0];
            e.d = v[15:0];
            e.cnt = 5'(pop(v[15:0]));
            e.oh = pop(v[15:0]) <= 1;
            e.sweep = 1'b1;
            q.push_back(e);
        end
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(q.size()), 32'd0);

        // Capture, then hold with en low.
        @(posedge clk);
        #1;
        en = 1'b1;
        data = 16'h0104;
        @(posedge clk);
        #1;
        chk("cap_ohq", 32'(ohq16), 32'd0);
        chk("cap_cntq", 32'(cntq16), 32'd2);
        en = 1'b0;
        data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_ohq", 32'(ohq16), 32'd0);
        chk("hold_cntq", 32'(cntq16), 32'd2);

        // Asynchronous reset between edges, with en high to show it overrides.
        #2;
        en = 1'b1;
        data = 16'h0003;
        reset = 1'b1;
        #1;
        chk("arst_cntq", 32'(cntq16), 32'd0);
        chk("arst_ohq", 32'(ohq16), 32'd1);
        chk("arst_cnt", 32'(cnt16), 32'd2);
        chk("arst_oh", 32'(oh16), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_cntq", 32'(cntq16), 32'd0);
        reset = 1'b0;
        data = 16'h0010;
        @(posedge clk);
        #1;
        chk("resume_ohq", 32'(ohq16), 32'd1);
        chk("resume_cntq", 32'(cntq16), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
